commit_unit: RTL and testbench
==============================

# commit_unit

Parametrised in-order instruction committer that joins each dispatched instruction from the EX FIFO with the result of the functional unit it was issued to. It sits between the dispatcher/functional units and the register file and program counter generator. Compared with the fixed two-unit committer, it supports `NUM_FU` result channels and registers its outputs. It also tracks a branch epoch, so it discards wrong-path instructions after a redirect. An optional retired-instruction counter is compiled in on request.

## Interface
- `NUM_FU`, 2: number of functional-unit result channels (2..8).
- `XLEN`, 32: data/PC width.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous and active-high.
- `exwb_axis_if`  axis_if.s  from EX FIFO.
  - tdata fields: `fu_sel[NUM_FU]`, `epoch` (1), `rd_wen` (1), `rd_addr` (5), plus opaque `ex_data` forwarded unchanged.
- `fuwb_axis_if[NUM_FU]`  axis_if.s array  FU results.
  - tdata fields: `result[XLEN]`, `taken` (1), `new_pc[XLEN]`.
- `wbrf_axis_if`  axis_if.m  to register file.
  - tdata fields: `wdata[XLEN]`, `rd_wen`, `rd_addr`, `ex_data`.
- `wbpcg_axis_if`  axis_if.m  to PC generator; tdata = `new_pc[XLEN]`.
- `instret`  out  64  retired-instruction count. Zero unless `COMMIT_INSTRET_EN` is defined.

## Operation
- **FU selection.** `fu_sel` selects the result channel.
  - Multi-hot: the lowest set index wins.
  - All-zero: the instruction needs no FU result. It commits with `wdata`=0 and no redirect.
- **Output slot free.** `out_free` = (!wbrf.tvalid || wbrf.tready) && (!wbpcg.tvalid || wbpcg.tready).
- **Commit fire.** `fire` = ex.tvalid && (selected fu.tvalid, or `fu_sel`==0) && `out_free`.
- **Ready outputs.**
  - `exwb.tready` = `out_free` && (selected fu.tvalid, or `fu_sel`==0).
  - `fuwb[i].tready` = `fire` && i is the selected index. Non-selected FUs never see tready.
- **Epoch.** Internal `cur_epoch` resets to 0.
  - Stale entry (ex.epoch != `cur_epoch`): on `fire`, pop both the EX entry and its FU result. Nothing is written to wbrf/wbpcg and `instret` does not increment.
  - Live entry with taken=0: load the wbrf register with `wdata`=result and the forwarded fields.
  - Live entry with taken=1: load wbrf as above, also load wbpcg with `new_pc`, and toggle `cur_epoch` on the same edge.
- **Output registers.** Hold value while tvalid && !tready. tvalid clears on handshake when no new `fire` occurs that cycle.
- **Back-to-back.** A new `fire` may coincide with the draining handshake; the register reloads.
- **instret.** Increments by 1 per live commit and wraps modulo 2^64.

## Timing
- Latency: 1 cycle from `fire` to wbrf.tvalid, and to wbpcg.tvalid for taken branches.
- Throughput: 1 commit/cycle when both sinks stay ready.
- All tready outputs are combinational from sink tready and source tvalid. All tvalid/tdata outputs are registered.
- **Reset** (asynchronous, any time, including mid-stall):
  - wbrf.tvalid=0, wbpcg.tvalid=0, `cur_epoch`=0, `instret`=0.
  - Pending output data is lost; no partial pop survives.
- **Simultaneous taken branch and stall.** A redirect is not issued unless both output slots are free. wbrf and wbpcg for one instruction always become valid on the same cycle.
- **Stale window.** Entries already in the EX FIFO with the old epoch are drained at one per cycle, provided their FU results arrive.
- **Sink back-pressure.** A stall on either sink blocks all commits, including stale discards.

## Configuration
- `COMMIT_INSTRET_EN`
  - Defined: a 64-bit counter drives `instret`.
  - Undefined: `instret` is tied to 0 and the counter register is not synthesised.
- Commit behaviour is otherwise identical in both builds.

## Test plan
- **ALU result.** NUM_FU=3. EX{fu_sel=001, epoch=0, rd=5}; FU0 result=0x1234 one cycle later. Expect wbrf.tvalid the cycle after fire with wdata=0x1234, rd_addr=5, and wbpcg idle.
- **Taken branch, then stale entry.** FU1{taken=1, new_pc=0x80}. Expect wbrf and wbpcg valid together with new_pc=0x80, and `cur_epoch` flipped. A following EX{epoch=0} is popped with no wbrf output.
- **Wrong-FU result.** FU2 valid while EX selects FU0. Expect FU2 never receives tready and no commit occurs until FU0 is valid.
- **Back-pressure.** Hold wbrf.tready=0 for 4 cycles with a commit pending. Expect stable wbrf tdata, exwb.tready=0, then resume at 1 commit/cycle.
- **fu_sel zero.** EX{fu_sel=000}. Expect commit without any FU handshake, wdata=0, and `instret` +1 with `COMMIT_INSTRET_EN`.
- **Reset during stall.** Assert rst with wbrf valid and stalled. Expect wbrf.tvalid=0 immediately, `instret`=0, and `cur_epoch`=0.

Source files
------------

// File: rtl/commit_unit.sv
`default_nettype none
// ============================================================================
// Module   : commit_unit
// Brief    : In-order committer. Pairs each EX FIFO entry with the result of
//            the functional unit it was issued to, and drops wrong-path
//            entries using a branch epoch. COMMIT_INSTRET_EN enables the
//            64-bit retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module commit_unit #(
  parameter int NUM_FU    = 2,
  parameter int XLEN      = 32,
  parameter int EX_DATA_W = 32
) (
  input  logic                           clk,
  input  logic                           rst,

  // EX FIFO entry
  input  logic                           exwb_tvalid,
  output logic                           exwb_tready,
  input  logic [NUM_FU-1:0]              exwb_fu_sel,
  input  logic                           exwb_epoch,
  input  logic                           exwb_rd_wen,
  input  logic [4:0]                     exwb_rd_addr,
  input  logic [EX_DATA_W-1:0]           exwb_ex_data,

  // functional-unit result channels
  input  logic [NUM_FU-1:0]              fuwb_tvalid,
  output logic [NUM_FU-1:0]              fuwb_tready,
  input  logic [NUM_FU-1:0][XLEN-1:0]    fuwb_result,
  input  logic [NUM_FU-1:0]              fuwb_taken,
  input  logic [NUM_FU-1:0][XLEN-1:0]    fuwb_new_pc,

  // register-file write-back
  output logic                           wbrf_tvalid,
  input  logic                           wbrf_tready,
  output logic [XLEN-1:0]                wbrf_wdata,
  output logic                           wbrf_rd_wen,
  output logic [4:0]                     wbrf_rd_addr,
  output logic [EX_DATA_W-1:0]           wbrf_ex_data,

  // PC-generator redirect
  output logic                           wbpcg_tvalid,
  input  logic                           wbpcg_tready,
  output logic [XLEN-1:0]                wbpcg_new_pc,

  output logic [63:0]                    instret
);

  generate
    if (NUM_FU < 2 || NUM_FU > 8) begin : g_num_fu_check
      $error("commit_unit: NUM_FU must be within 2..8");
    end
  endgenerate

  logic [NUM_FU-1:0] sel_onehot;
  logic              sel_hit;
  logic              sel_valid;
  logic              sel_taken;
  logic [XLEN-1:0]   sel_result;
  logic [XLEN-1:0]   sel_new_pc;
  logic              operand_ready;
  logic              out_free;
  logic              fire;
  logic              live;
  logic              commit;
  logic              redirect;
  logic              cur_epoch;

  logic                 rf_valid;
  logic [XLEN-1:0]      rf_wdata;
  logic                 rf_rd_wen;
  logic [4:0]           rf_rd_addr;
  logic [EX_DATA_W-1:0] rf_ex_data;
  logic                 pcg_valid;
  logic [XLEN-1:0]      pcg_new_pc;

  // x & -x isolates the lowest set bit, giving the winning channel one-hot.
  assign sel_onehot = exwb_fu_sel & (-exwb_fu_sel);
  assign sel_hit    = |exwb_fu_sel;
  assign sel_valid  = |(fuwb_tvalid & sel_onehot);
  assign sel_taken  = |(fuwb_taken & sel_onehot);

  always_comb begin
    sel_result = '0;
    sel_new_pc = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (sel_onehot[i]) begin
        sel_result = fuwb_result[i];
        sel_new_pc = fuwb_new_pc[i];
      end
    end
  end

  assign operand_ready = !sel_hit || sel_valid;
  assign out_free      = (!rf_valid || wbrf_tready) && (!pcg_valid || wbpcg_tready);
  assign fire          = exwb_tvalid && operand_ready && out_free;
  assign live          = (exwb_epoch == cur_epoch);
  assign commit        = fire && live;
  assign redirect      = commit && sel_hit && sel_taken;

  assign exwb_tready = out_free && operand_ready;
  assign fuwb_tready = {NUM_FU{fire}} & sel_onehot;

  // Both slots are known free whenever fire is high, so a load never
  // overwrites an undelivered beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_valid  <= 1'b0;
      pcg_valid <= 1'b0;
      cur_epoch <= 1'b0;
    end else begin
      if (commit) begin
        rf_valid <= 1'b1;
      end else if (wbrf_tready) begin
        rf_valid <= 1'b0;
      end

      if (redirect) begin
        pcg_valid <= 1'b1;
      end else if (wbpcg_tready) begin
        pcg_valid <= 1'b0;
      end

      if (redirect) begin
        cur_epoch <= ~cur_epoch;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wdata   <= '0;
      rf_rd_wen  <= 1'b0;
      rf_rd_addr <= '0;
      rf_ex_data <= '0;
      pcg_new_pc <= '0;
    end else begin
      if (commit) begin
        rf_wdata   <= sel_hit ? sel_result : '0;
        rf_rd_wen  <= exwb_rd_wen;
        rf_rd_addr <= exwb_rd_addr;
        rf_ex_data <= exwb_ex_data;
      end
      if (redirect) begin
        pcg_new_pc <= sel_new_pc;
      end
    end
  end

  assign wbrf_tvalid  = rf_valid;
  assign wbrf_wdata   = rf_wdata;
  assign wbrf_rd_wen  = rf_rd_wen;
  assign wbrf_rd_addr = rf_rd_addr;
  assign wbrf_ex_data = rf_ex_data;
  assign wbpcg_tvalid = pcg_valid;
  assign wbpcg_new_pc = pcg_new_pc;

`ifdef COMMIT_INSTRET_EN
  logic [63:0] instret_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_count <= '0;
    end else if (commit) begin
      instret_count <= instret_count + 64'd1;
    end
  end

  assign instret = instret_count;
`else
  assign instret = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_commit_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_unit
// Brief    : Randomised self-checking bench for commit_unit against a
//            transaction-level model of commit order, epochs and readies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_commit_unit;

  localparam int NF = 3;
  localparam int XL = 32;
  localparam int XD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic                   exwb_tvalid, exwb_tready;
  logic [NF-1:0]          exwb_fu_sel;
  logic                   exwb_epoch, exwb_rd_wen;
  logic [4:0]             exwb_rd_addr;
  logic [XD-1:0]          exwb_ex_data;
  logic [NF-1:0]          fuwb_tvalid, fuwb_tready, fuwb_taken;
  logic [NF-1:0][XL-1:0]  fuwb_result, fuwb_new_pc;
  logic                   wbrf_tvalid, wbrf_tready, wbrf_rd_wen;
  logic [XL-1:0]          wbrf_wdata;
  logic [4:0]             wbrf_rd_addr;
  logic [XD-1:0]          wbrf_ex_data;
  logic                   wbpcg_tvalid, wbpcg_tready;
  logic [XL-1:0]          wbpcg_new_pc;
  logic [63:0]            instret;

  always #5 clk = ~clk;

  commit_unit #(.NUM_FU(NF), .XLEN(XL), .EX_DATA_W(XD)) dut (
    .clk(clk), .rst(rst),
    .exwb_tvalid(exwb_tvalid), .exwb_tready(exwb_tready), .exwb_fu_sel(exwb_fu_sel),
    .exwb_epoch(exwb_epoch), .exwb_rd_wen(exwb_rd_wen), .exwb_rd_addr(exwb_rd_addr),
    .exwb_ex_data(exwb_ex_data),
    .fuwb_tvalid(fuwb_tvalid), .fuwb_tready(fuwb_tready), .fuwb_result(fuwb_result),
    .fuwb_taken(fuwb_taken), .fuwb_new_pc(fuwb_new_pc),
    .wbrf_tvalid(wbrf_tvalid), .wbrf_tready(wbrf_tready), .wbrf_wdata(wbrf_wdata),
    .wbrf_rd_wen(wbrf_rd_wen), .wbrf_rd_addr(wbrf_rd_addr), .wbrf_ex_data(wbrf_ex_data),
    .wbpcg_tvalid(wbpcg_tvalid), .wbpcg_tready(wbpcg_tready), .wbpcg_new_pc(wbpcg_new_pc),
    .instret(instret)
  );

  typedef struct {
    logic [NF-1:0] sel;
    logic          ep;
    logic          wen;
    logic [4:0]    rd;
    logic [XD-1:0] xd;
    logic [XL-1:0] res;
    logic          tk;
    logic [XL-1:0] npc;
  } instr_t;

  typedef struct {
    logic [XL-1:0] wdata;
    logic          wen;
    logic [4:0]    rd;
    logic [XD-1:0] xd;
  } rf_t;

  // Program: EX entries in dispatch order, plus per-channel FU result streams.
  instr_t        prog [512];
  int            prog_cnt, ex_ptr;
  logic [XL-1:0] fu_res [NF][512];
  logic          fu_tk  [NF][512];
  logic [XL-1:0] fu_npc [NF][512];
  int            fu_cnt [NF];
  int            fu_ptr [NF];

  // Model state and scoreboards
  rf_t           rf_q[$];
  logic [XL-1:0] pc_q[$];
  logic          m_epoch;
  logic [63:0]   m_instret;
  logic          ex_hs;
  logic [NF-1:0] fu_hs;
  logic [XL-1:0] obs_w[$];
  logic [4:0]    obs_rd[$];
  logic [XL-1:0] obs_pc[$];
  int            checks, errors;
  int            stall_left;

  function automatic int lowest(logic [NF-1:0] s);
    for (int i = 0; i < NF; i++) if (s[i]) return i;
    return -1;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_instr(logic [NF-1:0] sel, logic ep, logic wen, logic [4:0] rd,
                           logic [XD-1:0] xd, logic [XL-1:0] res, logic tk, logic [XL-1:0] npc);
    int l;
    l = lowest(sel);
    prog[prog_cnt].sel = sel;  prog[prog_cnt].ep  = ep;
    prog[prog_cnt].wen = wen;  prog[prog_cnt].rd  = rd;
    prog[prog_cnt].xd  = xd;   prog[prog_cnt].res = res;
    prog[prog_cnt].tk  = tk;   prog[prog_cnt].npc = npc;
    prog_cnt++;
    if (l >= 0) begin
      fu_res[l][fu_cnt[l]] = res;
      fu_tk [l][fu_cnt[l]] = tk;
      fu_npc[l][fu_cnt[l]] = npc;
      fu_cnt[l]++;
    end
  endtask

  task automatic clear_prog();
    prog_cnt = 0;
    ex_ptr   = 0;
    for (int i = 0; i < NF; i++) begin
      fu_cnt[i] = 0;
      fu_ptr[i] = 0;
    end
    obs_w.delete();
    obs_rd.delete();
    obs_pc.delete();
  endtask

  // Compare process: readies, output beats and instret against the model.
  int            c_l;
  logic          c_opnd, c_free, c_exr;
  logic [NF-1:0] c_fur;
  instr_t        c_in;
  rf_t           c_rf;

  always @(negedge clk) begin
    if (rst) begin
      ex_hs = 1'b0;
      fu_hs = '0;
    end else begin
      c_l    = lowest(exwb_fu_sel);
      c_opnd = (c_l < 0) || fuwb_tvalid[c_l];
      c_free = (!wbrf_tvalid || wbrf_tready) && (!wbpcg_tvalid || wbpcg_tready);
      c_exr  = c_free && c_opnd;
      c_fur  = '0;
      if (exwb_tvalid && c_exr && c_l >= 0) c_fur[c_l] = 1'b1;
      chk("exwb_tready", exwb_tready, c_exr);
      chk("fuwb_tready", fuwb_tready, c_fur);

      // A commit must be visible exactly one cycle after its fire.
      chk("wbrf_tvalid", wbrf_tvalid, rf_q.size() != 0);
      if (wbrf_tvalid && rf_q.size() != 0) begin
        chk("wbrf_wdata",   wbrf_wdata,   rf_q[0].wdata);
        chk("wbrf_rd_wen",  wbrf_rd_wen,  rf_q[0].wen);
        chk("wbrf_rd_addr", wbrf_rd_addr, rf_q[0].rd);
        chk("wbrf_ex_data", wbrf_ex_data, rf_q[0].xd);
      end
      chk("wbpcg_tvalid", wbpcg_tvalid, pc_q.size() != 0);
      if (wbpcg_tvalid && pc_q.size() != 0)
        chk("wbpcg_new_pc", wbpcg_new_pc, pc_q[0]);

`ifdef COMMIT_INSTRET_EN
      chk("instret", instret, m_instret);
`else
      chk("instret", instret, 64'd0);
`endif

      if (wbrf_tvalid && wbrf_tready) begin
        obs_w.push_back(wbrf_wdata);
        obs_rd.push_back(wbrf_rd_addr);
        if (rf_q.size() != 0) void'(rf_q.pop_front());
      end
      if (wbpcg_tvalid && wbpcg_tready) begin
        obs_pc.push_back(wbpcg_new_pc);
        if (pc_q.size() != 0) void'(pc_q.pop_front());
      end

      ex_hs = exwb_tvalid && exwb_tready;
      fu_hs = fuwb_tvalid & fuwb_tready;
      if (ex_hs && ex_ptr < prog_cnt) begin
        c_in = prog[ex_ptr];
        if (c_in.ep == m_epoch) begin
          c_rf.wdata = (c_in.sel != '0) ? c_in.res : '0;
          c_rf.wen   = c_in.wen;
          c_rf.rd    = c_in.rd;
          c_rf.xd    = c_in.xd;
          rf_q.push_back(c_rf);
          m_instret = m_instret + 64'd1;
          if (c_in.sel != '0 && c_in.tk) begin
            pc_q.push_back(c_in.npc);
            m_epoch = ~m_epoch;
          end
        end
      end
    end
  end

  task automatic drive_cycle(int ex_pct, int fu_pct, int rdy_pct);
    @(posedge clk);
    #1;
    if (ex_hs) ex_ptr++;
    for (int i = 0; i < NF; i++) if (fu_hs[i]) fu_ptr[i]++;

    if (!exwb_tvalid || ex_hs)
      exwb_tvalid = (ex_ptr < prog_cnt) && ($urandom_range(99) < ex_pct);
    if (ex_ptr < prog_cnt) begin
      exwb_fu_sel  = prog[ex_ptr].sel;  exwb_epoch   = prog[ex_ptr].ep;
      exwb_rd_wen  = prog[ex_ptr].wen;  exwb_rd_addr = prog[ex_ptr].rd;
      exwb_ex_data = prog[ex_ptr].xd;
    end else begin
      exwb_fu_sel  = NF'($urandom);     exwb_epoch   = 1'($urandom);
      exwb_rd_addr = 5'($urandom);
    end

    for (int i = 0; i < NF; i++) begin
      if (!fuwb_tvalid[i] || fu_hs[i])
        fuwb_tvalid[i] = (fu_ptr[i] < fu_cnt[i]) && ($urandom_range(99) < fu_pct);
      if (fu_ptr[i] < fu_cnt[i]) begin
        fuwb_result[i] = fu_res[i][fu_ptr[i]];
        fuwb_taken[i]  = fu_tk[i][fu_ptr[i]];
        fuwb_new_pc[i] = fu_npc[i][fu_ptr[i]];
      end else begin
        fuwb_result[i] = $urandom;
        fuwb_taken[i]  = 1'($urandom);
      end
    end

    // Occasional multi-cycle stall bursts on the register-file sink.
    if (stall_left > 0) begin
      wbrf_tready = 1'b0;
      stall_left--;
    end else if (rdy_pct > 0 && rdy_pct < 100 && $urandom_range(99) < 3) begin
      wbrf_tready = 1'b0;
      stall_left  = 3;
    end else begin
      wbrf_tready = ($urandom_range(99) < rdy_pct);
    end
    wbpcg_tready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic run_phase(int ex_pct, int fu_pct, int rdy_pct, int max_cycles);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    while (!done) begin
      drive_cycle(ex_pct, fu_pct, rdy_pct);
      n++;
      done = (ex_ptr >= prog_cnt) && rf_q.size() == 0 && pc_q.size() == 0 &&
             !wbrf_tvalid && !wbpcg_tvalid;
      for (int i = 0; i < NF; i++) if (fu_ptr[i] < fu_cnt[i]) done = 0;
      if (!done && n >= max_cycles) begin
        checks++;
        errors++;
        $display("FAIL phase_timeout: ran %0d cycles, limit %0d", n, max_cycles);
        done = 1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [XL-1:0] lit_w  [5];
    logic [4:0]    lit_rd [5];
    logic          gen_ep;
    int            w;

    lit_w  = '{32'h1234, 32'h55, 32'h0, 32'h77, 32'hCC};
    lit_rd = '{5'd5, 5'd6, 5'd8, 5'd9, 5'd10};

    checks = 0; errors = 0; stall_left = 0;
    m_epoch = 1'b0; m_instret = '0;
    ex_hs = 1'b0; fu_hs = '0;
    exwb_tvalid = 0; exwb_fu_sel = '0; exwb_epoch = 0; exwb_rd_wen = 0;
    exwb_rd_addr = '0; exwb_ex_data = '0;
    fuwb_tvalid = '0; fuwb_taken = '0; fuwb_result = '0; fuwb_new_pc = '0;
    wbrf_tready = 0; wbpcg_tready = 0;
    clear_prog();

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("reset_wbrf_tvalid",  wbrf_tvalid, 1'b0);
    chk("reset_wbpcg_tvalid", wbpcg_tvalid, 1'b0);
    chk("reset_instret",      instret, 64'd0);
    chk("reset_fuwb_tready",  fuwb_tready, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed: ALU commit, taken branch, stale drop, fu_sel zero, multi-hot
    add_instr(3'b001, 1'b0, 1'b1, 5'd5,  8'hA1, 32'h1234, 1'b0, 32'h0);
    add_instr(3'b010, 1'b0, 1'b1, 5'd6,  8'hA2, 32'h55,   1'b1, 32'h80);
    add_instr(3'b001, 1'b0, 1'b1, 5'd7,  8'hA3, 32'h99,   1'b0, 32'h0);
    add_instr(3'b000, 1'b1, 1'b1, 5'd8,  8'hA4, 32'hBEEF, 1'b1, 32'h444);
    add_instr(3'b110, 1'b1, 1'b1, 5'd9,  8'hA5, 32'h77,   1'b0, 32'h0);
    add_instr(3'b100, 1'b1, 1'b0, 5'd10, 8'hA6, 32'hCC,   1'b0, 32'h0);
    run_phase(100, 100, 100, 200);
    chk("dir_rf_count", obs_w.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < obs_w.size()) begin
        chk("dir_wdata", obs_w[i], lit_w[i]);
        chk("dir_rd",    obs_rd[i], lit_rd[i]);
      end
    end
    chk("dir_pc_count", obs_pc.size(), 1);
    if (obs_pc.size() != 0) chk("dir_new_pc", obs_pc[0], 32'h80);
`ifdef COMMIT_INSTRET_EN
    chk("dir_instret", instret, 64'd5);
`endif

    // Randomised traffic with stale entries, multi-hot selects and stalls
    clear_prog();
    gen_ep = m_epoch;
    for (int n = 0; n < 300; n++) begin
      logic [NF-1:0] sel;
      logic          tk, ep;
      sel = NF'($urandom_range(0, 7));
      tk  = ($urandom_range(99) < 15);
      ep  = ($urandom_range(99) < 15) ? ~gen_ep : gen_ep;
      if (sel != '0 && tk && ep == gen_ep) gen_ep = ~gen_ep;
      add_instr(sel, ep, 1'($urandom), 5'($urandom), XD'($urandom), $urandom, tk, $urandom);
    end
    run_phase(70, 60, 75, 8000);

    // Reset while a taken branch is held by stalled sinks
    clear_prog();
    add_instr(3'b001, m_epoch, 1'b1, 5'd4, 8'h11, 32'h42, 1'b1, 32'h100);
    w = 0;
    while (!wbrf_tvalid && w < 20) begin
      drive_cycle(100, 100, 0);
      w++;
    end
    repeat (3) drive_cycle(100, 100, 0);
    chk("stall_rf_valid",  wbrf_tvalid, 1'b1);
    chk("stall_rf_wdata",  wbrf_wdata, 32'h42);
    chk("stall_pcg_valid", wbpcg_tvalid, 1'b1);
    chk("stall_pcg_pc",    wbpcg_new_pc, 32'h100);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_wbrf_tvalid",  wbrf_tvalid, 1'b0);
    chk("midrst_wbpcg_tvalid", wbpcg_tvalid, 1'b0);
    chk("midrst_instret",      instret, 64'd0);
    rf_q.delete();
    pc_q.delete();
    m_epoch = 1'b0;
    m_instret = '0;
    exwb_tvalid = 1'b0;
    fuwb_tvalid = '0;
    clear_prog();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Epoch restarts at 0: an epoch-0 entry must commit
    add_instr(3'b000, 1'b0, 1'b1, 5'd3, 8'h22, 32'hDEAD, 1'b0, 32'h0);
    run_phase(100, 100, 100, 50);
    chk("postrst_count", obs_w.size(), 1);
    if (obs_w.size() != 0) begin
      chk("postrst_rd",    obs_rd[0], 5'd3);
      chk("postrst_wdata", obs_w[0], 32'h0);
    end
`ifdef COMMIT_INSTRET_EN
    chk("postrst_instret", instret, 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
